// File: rtl/stream_rr_arbiter.sv
// Two-source round-robin front end for a shared in-order streaming datapath.
// Issues one beat per cycle, tags each beat with its source, and steers results back.
module stream_rr_arbiter #(
  parameter int DATAW    = 16,
  parameter int TAGDEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s0_valid,
  output logic                        s0_ready,
  input  logic [DATAW-1:0]            s0_data,
  input  logic                        s1_valid,
  output logic                        s1_ready,
  input  logic [DATAW-1:0]            s1_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATAW-1:0]            m_data,
  input  logic                        r_valid,
  output logic                        r_ready,
  input  logic [2*DATAW-1:0]          r_data,
  output logic                        d0_valid,
  input  logic                        d0_ready,
  output logic [2*DATAW-1:0]          d0_data,
  output logic                        d1_valid,
  input  logic                        d1_ready,
  output logic [2*DATAW-1:0]          d1_data,
  output logic [$clog2(TAGDEPTH):0]   outstanding,
  output logic                        err
);

  localparam int PW = $clog2(TAGDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(TAGDEPTH);

  typedef enum logic {IDLE, HOLD} issue_state_e;

  issue_state_e state_q, state_d;
  logic         rr_ptr;
  logic         tag_mem [TAGDEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic         can_load, grant, accept;
  logic         fifo_empty, head_tag, pop;

  assign m_valid = (state_q == HOLD);

  // Full check looks only at the registered count, so a same-cycle return
  // frees a slot for the following cycle, never the current one.
  // NOTE: every signal driven here gets a default before any branch, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    can_load = !rst && (!m_valid || m_ready) && (outstanding != FULL);
    grant    = (s0_valid && s1_valid) ? rr_ptr : s1_valid;
    s0_ready = can_load && !grant;
    s1_ready = can_load && grant;
    accept   = (s0_valid && s0_ready) || (s1_valid && s1_ready);
  end

  always_comb begin
    fifo_empty = (outstanding == '0);
    head_tag   = tag_mem[rd_ptr];
    d0_valid   = !rst && r_valid && !fifo_empty && !head_tag;
    d1_valid   = !rst && r_valid && !fifo_empty && head_tag;
    d0_data    = r_data;
    d1_data    = r_data;
    r_ready    = !rst && !fifo_empty && (head_tag ? d1_ready : d0_ready);
    pop        = r_valid && r_ready;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = HOLD;
      HOLD: if (m_ready && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      m_data      <= '0;
      rr_ptr      <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        m_data <= grant ? s1_data : s0_data;
        rr_ptr <= !grant;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({accept, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (r_valid && fifo_empty) err <= 1'b1;
    end
  end

  // NOTE: tag storage has no reset; entries are only read once the pointers
  // (which are reset) mark them as written.
  always_ff @(posedge clk) begin
    if (accept) tag_mem[wr_ptr] <= grant;
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Scoreboard bench for stream_rr_arbiter: sources, a squaring datapath model
// and monitors run as separate processes; directed vectors carry hand-computed results.
module tb_stream_rr_arbiter;

  localparam int DW = 16;
  localparam int TD = 8;
  localparam int CW = $clog2(TD) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            s0_valid, s0_ready, s1_valid, s1_ready;
  logic [DW-1:0]   s0_data, s1_data;
  logic            m_valid, m_ready;
  logic [DW-1:0]   m_data;
  logic            r_valid, r_ready;
  logic [2*DW-1:0] r_data;
  logic            d0_valid, d0_ready, d1_valid, d1_ready;
  logic [2*DW-1:0] d0_data, d1_data;
  logic [CW-1:0]   outstanding;
  logic            err;

  stream_rr_arbiter #(.DATAW(DW), .TAGDEPTH(TD)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_data(s1_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .d0_valid(d0_valid), .d0_ready(d0_ready), .d0_data(d0_data),
    .d1_valid(d1_valid), .d1_ready(d1_ready), .d1_data(d1_data),
    .outstanding(outstanding), .err(err)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]          src0_q[$], src1_q[$], exp_issue[$];
  logic [2*DW-1:0]        exp_d0[$], exp_d1[$];
  logic signed [DW-1:0]   pend[$];
  logic                   inj = 1'b0;
  logic                   fire0, fire1;
  logic [DW-1:0]          e_issue;
  logic [2*DW-1:0]        e_d0, e_d1;
  int                     exp_occ = 0;
  logic                   occ_armed = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*DW-1:0] sq(input logic signed [DW-1:0] x);
    logic signed [2*DW-1:0] a;
    a = x;
    return a * a;
  endfunction

  // Source drivers: hold each queued operand until it is accepted.
  initial begin
    s0_valid = 1'b0; s0_data = '0;
    forever begin
      @(negedge clk);
      fire0 = s0_valid && s0_ready;
      @(posedge clk); #2;
      if (fire0 && src0_q.size() > 0) void'(src0_q.pop_front());
      s0_valid = (src0_q.size() > 0);
      s0_data  = (src0_q.size() > 0) ? src0_q[0] : '0;
    end
  end

  initial begin
    s1_valid = 1'b0; s1_data = '0;
    forever begin
      @(negedge clk);
      fire1 = s1_valid && s1_ready;
      @(posedge clk); #2;
      if (fire1 && src1_q.size() > 0) void'(src1_q.pop_front());
      s1_valid = (src1_q.size() > 0);
      s1_data  = (src1_q.size() > 0) ? src1_q[0] : '0;
    end
  end

  // Datapath model: in-order squarer, reset together with the arbiter.
  initial begin
    r_valid = 1'b0; r_data = '0;
    forever begin
      @(negedge clk);
      if (rst) pend.delete();
      else begin
        if (r_valid && r_ready && pend.size() > 0) void'(pend.pop_front());
        if (m_valid && m_ready) pend.push_back(m_data);
      end
      @(posedge clk); #2;
      if (inj) begin
        r_valid = 1'b1;
        r_data  = '0;
      end else begin
        r_valid = (pend.size() > 0);
        r_data  = (pend.size() > 0) ? sq(pend[0]) : '0;
      end
    end
  end

  // Scoreboard monitors for the issue port and both response ports.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && m_ready) begin
        if (exp_issue.size() == 0) begin
          checks++; errors++;
          $display("FAIL issue_unexpected: got m_data %0h, nothing expected", m_data);
        end else begin
          e_issue = exp_issue.pop_front();
          check("issue_data", 32'(m_data), 32'(e_issue));
        end
      end
      if (d0_valid && d0_ready) begin
        if (exp_d0.size() == 0) begin
          checks++; errors++;
          $display("FAIL d0_unexpected: got d0_data %0h, nothing expected", d0_data);
        end else begin
          e_d0 = exp_d0.pop_front();
          check("d0_data", d0_data, e_d0);
        end
      end
      if (d1_valid && d1_ready) begin
        if (exp_d1.size() == 0) begin
          checks++; errors++;
          $display("FAIL d1_unexpected: got d1_data %0h, nothing expected", d1_data);
        end else begin
          e_d1 = exp_d1.pop_front();
          check("d1_data", d1_data, e_d1);
        end
      end
      if (r_valid) check("d_valid_exclusive", 32'(d0_valid && d1_valid), 32'(0));
    end
  end

  // Occupancy tracker: count derived from observed handshakes.
  always @(negedge clk) begin
    if (occ_armed) check("outstanding_track", 32'(outstanding), exp_occ);
    check("s_ready_exclusive", 32'(s0_ready && s1_ready), 32'(0));
    if (rst) exp_occ = 0;
    else exp_occ = exp_occ + int'((s0_valid && s0_ready) || (s1_valid && s1_ready))
                           - int'(r_valid && r_ready);
    occ_armed = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    m_ready = 1'b1; d0_ready = 1'b1; d1_ready = 1'b1;
    repeat (3) tick();

    // Reset state
    @(negedge clk);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_data", 32'(m_data), 0);
    check("rst_outstanding", 32'(outstanding), 0);
    check("rst_err", 32'(err), 0);
    check("rst_s0_ready", 32'(s0_ready), 0);
    check("rst_s1_ready", 32'(s1_ready), 0);
    check("rst_r_ready", 32'(r_ready), 0);
    check("rst_d0_valid", 32'(d0_valid), 0);
    tick(); rst = 1'b0;

    // Single source: 5, -3 -> 25, 9 on d0 only
    tick();
    src0_q.push_back(16'd5); src0_q.push_back(-16'sd3);
    exp_issue.push_back(16'd5); exp_issue.push_back(-16'sd3);
    exp_d0.push_back(32'd25); exp_d0.push_back(32'd9);
    repeat (10) tick();
    @(negedge clk);
    check("t1_outstanding", 32'(outstanding), 0);
    check("t1_d0_drained", exp_d0.size(), 0);

    // Both sources continuously valid, round-robin from source 0
    tick(); rst = 1'b1;
    repeat (2) tick(); rst = 1'b0;
    tick();
    for (int i = 1; i <= 3; i++) begin
      src0_q.push_back(16'(i));
      src1_q.push_back(16'(10 * i));
      exp_issue.push_back(16'(i));
      exp_issue.push_back(16'(10 * i));
      exp_d0.push_back(32'(i * i));
      exp_d1.push_back(32'(100 * i * i));
    end
    repeat (15) tick();
    @(negedge clk);
    check("t2_drained", exp_d0.size() + exp_d1.size() + exp_issue.size(), 0);

    // Datapath stall while a beat is held
    tick();
    m_ready = 1'b0;
    src0_q.push_back(16'd7); src0_q.push_back(16'd9); src1_q.push_back(16'd8);
    exp_issue.push_back(16'd7); exp_issue.push_back(16'd8); exp_issue.push_back(16'd9);
    exp_d0.push_back(32'd49); exp_d0.push_back(32'd81); exp_d1.push_back(32'd64);
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold_m_valid", 32'(m_valid), 1);
      check("hold_m_data", 32'(m_data), 7);
      check("hold_s0_ready", 32'(s0_ready), 0);
      check("hold_s1_ready", 32'(s1_ready), 0);
      tick();
    end
    m_ready = 1'b1;
    @(negedge clk);
    check("release_s1_ready", 32'(s1_ready), 1);
    check("release_s0_ready", 32'(s0_ready), 0);
    repeat (12) tick();
    @(negedge clk);
    check("t3_drained", exp_d0.size() + exp_d1.size() + exp_issue.size(), 0);

    // Fill to TAGDEPTH with returns blocked
    tick();
    d0_ready = 1'b0; d1_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      src0_q.push_back(16'(i));
      exp_issue.push_back(16'(i));
      exp_d0.push_back(32'(i * i));
    end
    repeat (14) tick();
    @(negedge clk);
    check("full_outstanding", 32'(outstanding), 8);
    check("full_s0_ready", 32'(s0_ready), 0);
    check("full_s1_ready", 32'(s1_ready), 0);
    tick(); d0_ready = 1'b1;
    @(negedge clk);
    check("full_pop_r_ready", 32'(r_ready), 1);
    check("full_no_bypass", 32'(s0_ready), 0);
    tick(); d0_ready = 1'b0;
    @(negedge clk);
    check("after_pop_outstanding", 32'(outstanding), 7);
    check("after_pop_s0_ready", 32'(s0_ready), 1);
    tick();
    @(negedge clk);
    check("refill_outstanding", 32'(outstanding), 8);
    tick(); d0_ready = 1'b1;
    tick();
    @(negedge clk);
    check("pp_outstanding_before", 32'(outstanding), 7);
    check("pp_both_handshakes", 32'(s0_ready && r_ready && r_valid && s0_valid), 1);
    tick();
    @(negedge clk);
    check("pp_outstanding_after", 32'(outstanding), 7);
    d1_ready = 1'b1;
    repeat (20) tick();
    @(negedge clk);
    check("t4_drained", exp_d0.size() + exp_issue.size(), 0);

    // Head tag 1 blocked: no reordering toward d0
    tick();
    d0_ready = 1'b1; d1_ready = 1'b0;
    src1_q.push_back(16'd6); exp_issue.push_back(16'd6); exp_d1.push_back(32'd36);
    repeat (2) tick();
    src0_q.push_back(16'd4); exp_issue.push_back(16'd4); exp_d0.push_back(32'd16);
    repeat (6) tick();
    @(negedge clk);
    check("blk_r_valid", 32'(r_valid), 1);
    check("blk_d1_valid", 32'(d1_valid), 1);
    check("blk_d0_valid", 32'(d0_valid), 0);
    check("blk_r_ready", 32'(r_ready), 0);
    check("blk_outstanding", 32'(outstanding), 2);
    tick(); d1_ready = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    check("t5_drained", exp_d0.size() + exp_d1.size(), 0);

    // Result with empty tag FIFO
    tick(); inj = 1'b1;
    @(negedge clk);
    check("inj_r_ready", 32'(r_ready), 0);
    check("inj_d0_valid", 32'(d0_valid), 0);
    check("inj_d1_valid", 32'(d1_valid), 0);
    check("inj_err_before", 32'(err), 0);
    tick(); inj = 1'b0;
    @(negedge clk);
    check("err_set", 32'(err), 1);
    repeat (3) tick();
    @(negedge clk);
    check("err_sticky", 32'(err), 1);

    // Reset in the middle of a burst
    tick();
    d0_ready = 1'b0;
    for (int i = 1; i <= 5; i++) src0_q.push_back(16'(i));
    exp_issue.push_back(16'd1); exp_issue.push_back(16'd2);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    src0_q.delete();
    @(negedge clk);
    check("mrst_outstanding", 32'(outstanding), 0);
    check("mrst_m_valid", 32'(m_valid), 0);
    check("mrst_err", 32'(err), 0);
    tick(); rst = 1'b0;
    d0_ready = 1'b1;
    repeat (5) tick();

    @(negedge clk);
    check("final_issue_q", exp_issue.size(), 0);
    check("final_d0_q", exp_d0.size(), 0);
    check("final_d1_q", exp_d1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
